// File: rtl/serial_cfg_pkg.sv
// Shared types and constants for the serial configuration slave.
// Frame: R/W bit, address, data, all MSB first.
package serial_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StRdata,
    StDone
  } state_t;

  // Levels the synchronisers hold in reset: deselected, clock low, data low.
  localparam logic SenIdle  = 1'b1;
  localparam logic SclkIdle = 1'b0;
  localparam logic SdiIdle  = 1'b0;

  function automatic int unsigned frame_len(input int unsigned addr_w,
                                            input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
module cdc_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/serial_cfg_slave.sv
// Serial register-write slave clocked by master_clk with oversampled sen_n/sclk/sdi.
// Define SERIAL_READBACK_EN to enable read frames shifting rb_data out on sdo.
module serial_cfg_slave
  import serial_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              sen_n,
  input  logic              sclk,
  input  logic              sdi,
  output logic              sdo,
  output logic              serial_strobe,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  input  logic [DATA_W-1:0] rb_data,
  output logic [7:0]        frame_err
);

  localparam int unsigned FrameLen = frame_len(ADDR_W, DATA_W);
  localparam int unsigned CntW     = $clog2(FrameLen + 1);
  localparam int unsigned FlushW   = $clog2(SYNC_STAGES + 1);
`ifdef SERIAL_READBACK_EN
  localparam logic ReadOk = 1'b1;
`else
  localparam logic ReadOk = 1'b0;
`endif

  logic w_sen, w_sclk, w_sdi;

  cdc_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SenIdle)) u_sync_sen (
    .i_clk(master_clk), .i_rst_n(reset_n), .i_d(sen_n), .o_q(w_sen)
  );
  cdc_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SclkIdle)) u_sync_sclk (
    .i_clk(master_clk), .i_rst_n(reset_n), .i_d(sclk), .o_q(w_sclk)
  );
  cdc_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SdiIdle)) u_sync_sdi (
    .i_clk(master_clk), .i_rst_n(reset_n), .i_d(sdi), .o_q(w_sdi)
  );

  state_t              r_state;
  logic                r_sen_d, r_sclk_d, r_armed, r_rw, r_over, r_strobe;
  logic [FlushW-1:0]   r_flush;
  logic [CntW-1:0]     r_cnt;
  logic [FrameLen-1:0] r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_err;

  logic                w_sen_fall, w_sen_rise, w_sclk_rise, w_addr_last, w_good;
  logic [CntW-1:0]     w_cnt_next;
  logic [FrameLen-1:0] w_shift_next;
  logic [7:0]          w_err_inc;

  // Falls are only honoured once sen_n has been seen high after reset, so a frame
  // already running at reset release is never decoded.
  assign w_sen_fall   = r_armed & r_sen_d & ~w_sen;
  assign w_sen_rise   = ~r_sen_d & w_sen;
  assign w_sclk_rise  = ~w_sen & w_sclk & ~r_sclk_d;
  assign w_cnt_next   = r_cnt + 1'b1;
  assign w_shift_next = {r_shift[FrameLen-2:0], w_sdi};
  assign w_addr_last  = (r_state == StAddr) && w_sclk_rise &&
                        (w_cnt_next == CntW'(1 + ADDR_W));
  assign w_good       = (r_state == StDone) && !r_over && (!r_rw || ReadOk);
  assign w_err_inc    = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_sen_d  <= SenIdle;
      r_sclk_d <= SclkIdle;
      r_flush  <= '0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_rw     <= 1'b0;
      r_over   <= 1'b0;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= '0;
    end else begin
      r_sen_d  <= w_sen;
      r_sclk_d <= w_sclk;
      r_strobe <= 1'b0;
      if (r_flush != FlushW'(SYNC_STAGES)) begin
        r_flush <= r_flush + 1'b1;
      end else if (w_sen) begin
        r_armed <= 1'b1;
      end
      if (w_sen_fall) begin
        if (r_state != StIdle) r_err <= w_err_inc;
        r_state <= StAddr;
        r_cnt   <= '0;
        r_over  <= 1'b0;
      end else if (w_sen_rise) begin
        if (w_good) begin
          if (!r_rw) begin
            r_strobe <= 1'b1;
            r_data   <= r_shift[DATA_W-1:0];
          end
        end else if (r_state != StIdle) begin
          r_err <= w_err_inc;
        end
        r_state <= StIdle;
      end else if (w_sclk_rise) begin
        unique case (r_state)
          StAddr: begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            if (w_addr_last) begin
              r_addr  <= w_shift_next[ADDR_W-1:0];
              r_rw    <= w_shift_next[ADDR_W];
              r_state <= w_shift_next[ADDR_W] ? StRdata : StWdata;
            end
          end
          StWdata, StRdata: begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
            if (w_cnt_next == CntW'(FrameLen)) r_state <= StDone;
          end
          StDone:  r_over <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign serial_strobe = r_strobe;
  assign serial_addr   = r_addr;
  assign serial_data   = r_data;
  assign frame_err     = r_err;

`ifdef SERIAL_READBACK_EN
  logic [DATA_W-1:0] r_rb;
  logic              r_sdo;
  logic              w_sclk_fall;

  assign w_sclk_fall = ~w_sen & ~w_sclk & r_sclk_d;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rb  <= '0;
      r_sdo <= 1'b0;
    end else if (w_addr_last && w_shift_next[ADDR_W]) begin
      r_rb  <= rb_data;
      r_sdo <= 1'b0;
    end else if ((r_state == StRdata) && w_sclk_fall) begin
      r_sdo <= r_rb[DATA_W-1];
      r_rb  <= r_rb << 1;
    end else if (r_state != StRdata) begin
      r_sdo <= 1'b0;
    end
  end

  assign sdo = r_sdo;
`else
  logic w_unused_rb;
  assign w_unused_rb = ^rb_data;
  assign sdo         = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cfg_slave.sv
// Randomised self-checking bench for serial_cfg_slave: default instance and a 4/16-bit one.
module tb_serial_cfg_slave;

`ifdef SERIAL_READBACK_EN
  localparam bit RbEn = 1'b1;
`else
  localparam bit RbEn = 1'b0;
`endif

  logic        clk, rst_n;
  logic [1:0]  sen_n, sclk, sdi;
  logic        sdo_a, sdo_b, stb_a, stb_b;
  logic [6:0]  addr_a;
  logic [31:0] data_a, rb_a;
  logic [3:0]  addr_b;
  logic [15:0] data_b, rb_b;
  logic [7:0]  err_a, err_b;

  serial_cfg_slave u_dut_a (
    .master_clk(clk), .reset_n(rst_n), .sen_n(sen_n[0]), .sclk(sclk[0]), .sdi(sdi[0]),
    .sdo(sdo_a), .serial_strobe(stb_a), .serial_addr(addr_a), .serial_data(data_a),
    .rb_data(rb_a), .frame_err(err_a)
  );

  serial_cfg_slave #(.ADDR_W(4), .DATA_W(16)) u_dut_b (
    .master_clk(clk), .reset_n(rst_n), .sen_n(sen_n[1]), .sclk(sclk[1]), .sdi(sdi[1]),
    .sdo(sdo_b), .serial_strobe(stb_b), .serial_addr(addr_b), .serial_data(data_b),
    .rb_data(rb_b), .frame_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference expectations per instance
  logic [7:0]  exp_addr [2];
  logic [31:0] exp_data [2];
  int          exp_err  [2];
  int          exp_stb  [2];

  // Strobe monitor: high cycles and rising edges must both equal expected writes
  int   stb_hi   [2] = '{0, 0};
  int   stb_rise [2] = '{0, 0};
  logic [1:0] stb_q = 2'b00;
  always @(posedge clk) begin
    stb_q <= {stb_b, stb_a};
    if (stb_a) stb_hi[0] <= stb_hi[0] + 1;
    if (stb_b) stb_hi[1] <= stb_hi[1] + 1;
    if (stb_a && !stb_q[0]) stb_rise[0] <= stb_rise[0] + 1;
    if (stb_b && !stb_q[1]) stb_rise[1] <= stb_rise[1] + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input int w, input string tag);
    if (w == 0) begin
      check({tag, " addr_a"}, 64'(addr_a), 64'(exp_addr[0]));
      check({tag, " data_a"}, 64'(data_a), 64'(exp_data[0]));
      check({tag, " err_a"}, 64'(err_a), 64'(exp_err[0]));
      check({tag, " sdo_a idle"}, 64'(sdo_a), 64'd0);
    end else begin
      check({tag, " addr_b"}, 64'(addr_b), 64'(exp_addr[1]));
      check({tag, " data_b"}, 64'(data_b), 64'(exp_data[1]));
      check({tag, " err_b"}, 64'(err_b), 64'(exp_err[1]));
      check({tag, " sdo_b idle"}, 64'(sdo_b), 64'd0);
    end
    check({tag, " strobe cycles"}, 64'(stb_hi[w]), 64'(exp_stb[w]));
    check({tag, " strobe pulses"}, 64'(stb_rise[w]), 64'(exp_stb[w]));
  endtask

  // Send one frame of nbits bits; rst_at >= 0 pulses reset during that bit.
  task automatic send(input int w, input logic rw, input logic [7:0] addr,
                      input logic [31:0] data, input logic [31:0] rb, input int nbits,
                      input int rst_at, input string tag);
    int          aw, dw, fl;
    logic        b;
    logic [31:0] rd, rb_m, d_m;
    logic [7:0]  a_m;
    bit          good, was_reset;
    aw   = (w == 0) ? 7 : 4;
    dw   = (w == 0) ? 32 : 16;
    fl   = 1 + aw + dw;
    a_m  = 8'((1 << aw) - 1) & addr;
    d_m  = (dw == 32) ? data : (data & 32'hFFFF);
    rb_m = (dw == 32) ? rb : (rb & 32'hFFFF);
    rd   = '0;
    was_reset = 1'b0;
    if (w == 0) rb_a = rb; else rb_b = rb[15:0];
    sen_n[w] = 1'b0;
    #70;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) b = rw;
      else if (i <= aw) b = a_m[aw-i];
      else if (i <= aw + dw) b = d_m[aw+dw-i];
      else b = 1'($urandom);
      sdi[w] = b;
      #60;
      if (i > aw && i <= aw + dw) rd = {rd[30:0], (w == 0) ? sdo_a : sdo_b};
      sclk[w] = 1'b1;
      if (i == rst_at) begin
        #20 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        #20;
        was_reset = 1'b1;
      end else begin
        #60;
      end
      sclk[w] = 1'b0;
    end
    #70;
    sen_n[w] = 1'b1;
    #200;
    if (was_reset) begin
      for (int k = 0; k < 2; k++) begin
        exp_addr[k] = '0;
        exp_data[k] = '0;
        exp_err[k]  = 0;
      end
    end else begin
      if (nbits >= 1 + aw) exp_addr[w] = a_m;
      good = (nbits == fl) && (!rw || RbEn);
      if (good && !rw) begin
        exp_data[w] = d_m;
        exp_stb[w]++;
      end
      if (!good && exp_err[w] < 255) exp_err[w]++;
      if (rw && nbits >= fl) check({tag, " sdo word"}, 64'(rd), RbEn ? 64'(rb_m) : 64'd0);
    end
    check_state(w, tag);
  endtask

  initial begin
    int w, nb, fl;
    rst_n = 1'b0;
    sen_n = 2'b11;
    sclk  = 2'b00;
    sdi   = 2'b00;
    rb_a  = '0;
    rb_b  = '0;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = '0;
      exp_data[k] = '0;
      exp_err[k]  = 0;
      exp_stb[k]  = 0;
    end
    #23;
    check_state(0, "reset");
    check_state(1, "reset");
    #10 rst_n = 1'b1;
    #200;

    send(0, 1'b0, 8'd5, 32'h01234567, 32'h0, 40, -1, "write");
    send(0, 1'b1, 8'd9, 32'h0, 32'hDEADBEEF, 40, -1, "read");
    send(0, 1'b0, 8'd3, 32'hCAFEF00D, 32'h0, 20, -1, "truncated");
    send(0, 1'b0, 8'd7, 32'h55AA55AA, 32'h0, 41, -1, "overlength");
    send(1, 1'b0, 8'hA, 32'h1234, 32'h0, 21, -1, "narrow write");
    send(0, 1'b0, 8'd17, 32'h89ABCDEF, 32'h0, 40, 20, "reset mid-data");
    send(0, 1'b0, 8'd33, 32'h0BADCAFE, 32'h0, 40, -1, "write after reset");
    send(0, 1'b0, 8'd0, 32'h0, 32'h0, 0, -1, "empty frame");

    for (int n = 0; n < 24; n++) begin
      w  = n % 2;
      fl = (w == 0) ? 40 : 21;
      nb = ($urandom_range(0, 3) == 2) ? int'($urandom_range(0, fl + 2)) : fl;
      send(w, 1'($urandom_range(0, 3) == 0), 8'($urandom), $urandom, $urandom, nb, -1,
           "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
